// File: rtl/rand_pkg.sv
// Shared definitions for the rand_draw slice: LFSR width, LFSR state type
// and a pointer-width helper that never returns zero.
package rand_pkg;

  localparam int RND_W = 16;

  typedef logic [RND_W-1:0] rnd_t;

  // Bits needed to index 'depth' entries; a single-entry range still gets one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rand_draw_if.sv
// Consumer-side handshake of rand_draw: valid/ready/data plus FIFO occupancy.
// The drawer is the master; game logic is the slave.
interface rand_draw_if #(
  parameter int OUT_W = 4,
  parameter int DEPTH = 8
) ();

  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;

  modport master (
    output out_valid,
    output out_data,
    output count,
    output full,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  count,
    input  full,
    output out_ready
  );

endinterface

// File: rtl/rand_fifo.sv
// Small synchronous FIFO for accepted draws. The head is read straight from
// storage, so data is stable while it is not popped. A push that coincides
// with a pop is allowed when full; the new value goes behind the survivors.
module rand_fifo
  import rand_pkg::*;
#(
  parameter  int W     = 4,
  parameter  int DEPTH = 8,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads 0 straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally; count tracks push/pop and is bounded by the guards above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rand_draw.sv
// rand_draw: decimates the free-running LFSR so every draw uses OUT_W fresh
// bits, rejection-samples the candidate against 'limit' and queues accepted
// values for the consumer.
// Optional feature macro RAND_DRAW_STATS_EN adds a saturating 16-bit
// 'reject_cnt' output counting rejected plus dropped candidates.
module rand_draw
  import rand_pkg::*;
#(
  parameter int OUT_W = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  rnd_t             rnd,
  input  logic             enable,
  input  logic [OUT_W-1:0] limit,
  rand_draw_if.master      bus
`ifdef RAND_DRAW_STATS_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  localparam int             SW   = ptr_w(OUT_W);
  localparam logic [SW-1:0]  LAST = SW'(OUT_W - 1);
  localparam int             CW   = $clog2(DEPTH) + 1;

  logic [SW-1:0]    stride;
  logic [OUT_W-1:0] candidate;
  logic             sample;
  logic             accept;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [OUT_W-1:0] fifo_dout;
  logic             unused_rnd;

  // Only the low OUT_W bits feed a draw; the rest of the LFSR is ignored.
  assign unused_rnd = ^rnd;

  assign candidate = rnd[OUT_W-1:0];
  assign sample    = enable && (stride == LAST);
  assign accept    = sample && (candidate < limit);
  assign pop       = !fifo_empty && bus.out_ready;
  assign push      = accept && (!fifo_full || pop);
  assign drop      = accept && fifo_full && !pop;

  // Stride counter: one sample every OUT_W enabled cycles, frozen while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stride <= '0;
    end else if (enable) begin
      stride <= (stride == LAST) ? '0 : stride + 1'b1;
    end
  end

  rand_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (candidate),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout;
  assign bus.count     = fifo_count;
  assign bus.full      = fifo_full;

`ifdef RAND_DRAW_STATS_EN
  // Counts every sample that did not make it into the FIFO, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject_cnt <= '0;
    end else if (((sample && !accept) || drop) && (reject_cnt != 16'hFFFF)) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end
`endif

endmodule
